// File: rtl/mem_responder.sv
// mem_responder: byte-wide RAM responder on the 8-bit memory bus (1-cycle registered reads).
// Define MEM_RESPONDER_IO_EN to add the 0x30000 I/O window with RX/TX byte FIFOs and a status register.
module mem_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int FIFO_AW    = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    logic [7:0]            ram_r [2**RAM_ADDR_W];
    logic [RAM_ADDR_W-1:0] ram_addr_s;
    logic                  io_sel_s;
    logic [7:0]            io_rd_data_s;
    logic                  unused_s;

    assign ram_addr_s = mem_a[RAM_ADDR_W-1:0];

    // RAM write port; contents survive reset
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && mem_wr && !io_sel_s) begin
            ram_r[ram_addr_s] <= mem_dout;
        end
    end

    // Read data register: updates only on enabled reads, holds on writes and stalls
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mem_din <= 8'h00;
        end else if (rdy_in && !mem_wr) begin
            if (io_sel_s) begin
                mem_din <= io_rd_data_s;
            end else begin
                mem_din <= ram_r[ram_addr_s];
            end
        end else begin
            mem_din <= mem_din;
        end
    end

`ifdef MEM_RESPONDER_IO_EN

    localparam int DEPTH = 2**FIFO_AW;
    typedef logic [FIFO_AW:0] ptr_t;
    localparam ptr_t PTR_ZERO = ptr_t'(0);
    localparam ptr_t PTR_ONE  = ptr_t'(1);

    function automatic logic fifo_empty(input ptr_t wp, input ptr_t rp);
        return (wp == rp);
    endfunction

    // Extra pointer bit distinguishes a full ring from an empty one
    function automatic logic fifo_full(input ptr_t wp, input ptr_t rp);
        return (wp[FIFO_AW] != rp[FIFO_AW]) && (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
    endfunction

    logic [7:0] rx_mem_r [DEPTH];
    logic [7:0] tx_mem_r [DEPTH];
    ptr_t       rx_wp_r;
    ptr_t       rx_rp_r;
    ptr_t       tx_wp_r;
    ptr_t       tx_rp_r;
    logic       rx_empty_s;
    logic       rx_full_s;
    logic       tx_empty_s;
    logic       tx_full_s;
    logic       rx_push_s;
    logic       rx_pop_s;
    logic       tx_push_s;
    logic       tx_pop_s;
    logic       data_rd_s;
    logic       data_wr_s;
    logic       stat_wr_s;
    logic       rx_rd_prev_r;
    logic       tx_ovf_r;
    logic [7:0] rx_head_s;
    logic [7:0] tx_head_s;

    assign io_sel_s   = (mem_a[17:16] == 2'b11);
    assign data_rd_s  = io_sel_s && !mem_wr && (mem_a[2:0] == 3'd0);
    assign data_wr_s  = io_sel_s && mem_wr && (mem_a[2:0] == 3'd0);
    assign stat_wr_s  = io_sel_s && mem_wr && (mem_a[2:0] == 3'd4);

    assign rx_empty_s = fifo_empty(rx_wp_r, rx_rp_r);
    assign rx_full_s  = fifo_full(rx_wp_r, rx_rp_r);
    assign tx_empty_s = fifo_empty(tx_wp_r, tx_rp_r);
    assign tx_full_s  = fifo_full(tx_wp_r, tx_rp_r);
    assign rx_head_s  = rx_mem_r[rx_rp_r[FIFO_AW-1:0]];
    assign tx_head_s  = tx_mem_r[tx_rp_r[FIFO_AW-1:0]];

    assign rx_ready   = rst_in && !rx_full_s;
    assign rx_push_s  = rx_valid && rx_ready;
    // Only the first cycle of a held RX data read pops
    assign rx_pop_s   = rdy_in && data_rd_s && !rx_rd_prev_r && !rx_empty_s;
    assign tx_push_s  = rdy_in && data_wr_s && !tx_full_s;
    assign tx_valid   = rst_in && !tx_empty_s;
    assign tx_data    = tx_valid ? tx_head_s : 8'h00;
    assign tx_pop_s   = tx_valid && tx_ready;
    assign unused_s   = ^mem_a[31:RAM_ADDR_W];

    // I/O read mux; a repeated RX data read re-drives the byte already on mem_din
    always_comb begin
        io_rd_data_s = 8'h00;
        case (mem_a[2:0])
            3'd0: begin
                if (rx_rd_prev_r) begin
                    io_rd_data_s = mem_din;
                end else if (!rx_empty_s) begin
                    io_rd_data_s = rx_head_s;
                end else begin
                    io_rd_data_s = 8'h00;
                end
            end
            3'd4:    io_rd_data_s = {5'b00000, tx_ovf_r, tx_full_s, !rx_empty_s};
            default: io_rd_data_s = 8'h00;
        endcase
    end

    // RX pointers: stream push and CPU pop are independent of each other
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rx_wp_r <= PTR_ZERO;
            rx_rp_r <= PTR_ZERO;
        end else begin
            rx_wp_r <= rx_push_s ? rx_wp_r + PTR_ONE : rx_wp_r;
            rx_rp_r <= rx_pop_s  ? rx_rp_r + PTR_ONE : rx_rp_r;
        end
    end

    // TX pointers: CPU push and stream pop
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            tx_wp_r <= PTR_ZERO;
            tx_rp_r <= PTR_ZERO;
        end else begin
            tx_wp_r <= tx_push_s ? tx_wp_r + PTR_ONE : tx_wp_r;
            tx_rp_r <= tx_pop_s  ? tx_rp_r + PTR_ONE : tx_rp_r;
        end
    end

    // FIFO storage; data need no reset since pointers gate visibility
    always_ff @(posedge clk_in) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wp_r[FIFO_AW-1:0]] <= rx_data;
        end
        if (tx_push_s) begin
            tx_mem_r[tx_wp_r[FIFO_AW-1:0]] <= mem_dout;
        end
    end

    // Pop history and sticky overflow, both frozen while rdy_in is low
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rx_rd_prev_r <= 1'b0;
            tx_ovf_r     <= 1'b0;
        end else if (rdy_in) begin
            rx_rd_prev_r <= data_rd_s;
            if (data_wr_s && tx_full_s) begin
                tx_ovf_r <= 1'b1;
            end else if (stat_wr_s && mem_dout[0]) begin
                tx_ovf_r <= 1'b0;
            end else begin
                tx_ovf_r <= tx_ovf_r;
            end
        end else begin
            rx_rd_prev_r <= rx_rd_prev_r;
            tx_ovf_r     <= tx_ovf_r;
        end
    end

`else

    assign io_sel_s     = 1'b0;
    assign io_rd_data_s = 8'h00;
    assign rx_ready     = 1'b0;
    assign tx_valid     = 1'b0;
    assign tx_data      = 8'h00;
    assign unused_s     = ^{mem_a[31:RAM_ADDR_W], rx_valid, rx_data, tx_ready, 1'(FIFO_AW)};

`endif

endmodule
